uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, detects the start edge from idle and
// samples each bit at its midpoint, reporting good bytes and framing errors.
module uart_rx #(
  parameter int BIT_CYCLES = 20834
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = $clog2(BIT_CYCLES);

  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             sync1_q, rxd_s_q, rxd_d_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;

  // Synchroniser and edge flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
      rxd_d_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxd_s_q <= sync1_q;
      rxd_d_q <= rxd_s_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rxd_d_q && !rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxd_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          shift_d[bit_idx_q] = rxd_s_q;
          cnt_d              = '0;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rxd_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: frame table plus
// hand-written glitch, break, reset-abort and back-to-back sequences.
module tb_uart_rx;

  localparam int BC = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx #(.BIT_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard / pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_rx_valid", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        check("sb_rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      check("rx_valid_width", 32'(prev_valid), 32'd0);
    end
    if (frame_err) begin
      ferr_cnt++;
      check("frame_err_width", 32'(prev_ferr), 32'd0);
    end
    if (rx_valid && frame_err) check("valid_and_ferr", 32'd1, 32'd0);
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    wait_cycles(BC);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_cycles(BC);
    end
    rxd = stop;
    wait_cycles(BC);
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_rx_data;
  } vec_t;

  vec_t vecs[6];
  int v0, f0;

  initial begin
    vecs[0] = '{8'h12, 1'b1, 1, 0, 8'h12};
    vecs[1] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[3] = '{8'h81, 1'b1, 1, 0, 8'h81};
    vecs[4] = '{8'h55, 1'b0, 0, 1, 8'h81};
    vecs[5] = '{8'h3C, 1'b1, 1, 0, 8'h3C};

    wait_cycles(3);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    wait_cycles(5);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      if (vecs[i].exp_valid != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      wait_cycles(20);
      check($sformatf("vec%0d_valid_pulses", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ferr_pulses", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx_data));
      check($sformatf("vec%0d_busy_idle", i), 32'(busy), 32'd0);
    end

    // back-to-back frames, no idle gap
    v0 = valid_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h00, 1'b1);
    wait_cycles(20);
    check("b2b_valid_pulses", 32'(valid_cnt - v0), 32'd2);
    check("b2b_gap_cycles", 32'(last_valid_cyc - prev_valid_cyc), 32'(10 * BC));
    check("b2b_rx_data", 32'(rx_data), 32'h00);

    // 3-cycle glitch on an idle line
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rxd = 1'b0;
    wait_cycles(3);
    rxd = 1'b1;
    wait_cycles(3);
    check("glitch_busy_during_check", 32'(busy), 32'd1);
    wait_cycles(6);
    check("glitch_busy_low_by_12", 32'(busy), 32'd0);
    wait_cycles(10);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    // stop bit low followed by a 100-cycle break
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    wait_cycles(100);
    check("break_ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
    check("break_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("break_rx_data_kept", 32'(rx_data), 32'h00);
    check("break_stays_idle", 32'(busy), 32'd0);
    rxd = 1'b1;
    wait_cycles(10);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_cycles(20);
    check("after_break_valid", 32'(valid_cnt - v0), 32'd1);
    check("after_break_rx_data", 32'(rx_data), 32'h3C);

    // reset during data bit 4 of 0xFF
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rxd = 1'b0;
    wait_cycles(BC);
    rxd = 1'b1;
    wait_cycles(4 * BC + BC / 2);
    check("midframe_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    wait_cycles(4);
    check("midframe_reset_rx_data", 32'(rx_data), 32'd0);
    check("midframe_reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_cycles(4 * BC);
    check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("abort_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_cycles(20);
    check("post_reset_valid", 32'(valid_cnt - v0), 32'd1);
    check("post_reset_rx_data", 32'(rx_data), 32'h5A);

    // transmitter-style loopback: two 0x12 frames with idle gaps
    v0 = valid_cnt;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1);
      wait_cycles(2 * BC);
    end
    check("loopback_valid_pulses", 32'(valid_cnt - v0), 32'd2);
    check("loopback_rx_data", 32'(rx_data), 32'h12);
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
